// File: rtl/data_gen_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one data generator.
// A winner is granted and the generator's read handshake is run: read high
// for two cycles, then low for one. The captured word goes back to the winner
// with a one-cycle rsp_valid pulse.
//
// Handshake semantics: req is a level. While a request is pending, gnt marks
// the winner for the ASSERT and CAPTURE cycles. rsp_valid[i] pulses for
// exactly one cycle with rsp_data when the word for requester i is ready.
// There is no back-pressure on the response side. A transaction that has been
// granted always completes, regardless of req or enable; only srst aborts it.
module data_gen_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              srst,
  input  logic              enable,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              gen_enable,
  output logic              gen_read,
  input  logic [DATA_W-1:0] gen_data,
  output logic [1:0]        state_dbg
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [N_REQ-1:0]  gnt_d, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              gen_read_d, busy_d;
  logic [IW-1:0]     rr_ptr, rr_ptr_d;
  logic [IW-1:0]     gnt_idx, gnt_idx_d;
  logic [IW-1:0]     win_idx;
  logic [IW:0]       cand;

  assign state_dbg = state;

  // Round-robin search: the lowest offset from rr_ptr with req set wins.
  // Scanning from the highest offset down lets the nearest hit overwrite.
  always_comb begin
    win_idx = '0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (req[cand[IW-1:0]]) win_idx = cand[IW-1:0];
    end
  end

  // Next-state and next-output logic. Every output is registered below.
  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    gen_read_d  = gen_read;
    rr_ptr_d    = rr_ptr;
    gnt_idx_d   = gnt_idx;
    case (state)
      IDLE, RELEASE: begin
        if (enable && (|req)) begin
          state_d    = ASSERT;
          gnt_d      = ONE << win_idx;
          gnt_idx_d  = win_idx;
          gen_read_d = 1'b1;
        end else begin
          state_d    = IDLE;
          gnt_d      = '0;
          gen_read_d = 1'b0;
        end
      end
      ASSERT: begin
        // The generator increments on this edge; its new word shows up in CAPTURE.
        state_d    = CAPTURE;
        gen_read_d = 1'b1;
      end
      CAPTURE: begin
        state_d     = RELEASE;
        rsp_data_d  = gen_data;
        rsp_valid_d = gnt;
        gnt_d       = '0;
        gen_read_d  = 1'b0;
        rr_ptr_d    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = '0;
        gen_read_d = 1'b0;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  // State and output registers, cleared asynchronously by srst.
  always_ff @(posedge clock or posedge srst) begin
    if (srst) begin
      state      <= IDLE;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      gen_read   <= 1'b0;
      gen_enable <= 1'b0;
      busy       <= 1'b0;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      gen_read   <= gen_read_d;
      gen_enable <= busy_d;
      busy       <= busy_d;
      rr_ptr     <= rr_ptr_d;
      gnt_idx    <= gnt_idx_d;
    end
  end

endmodule

// File: tb/tb_data_gen_arbiter.sv
// Bench for data_gen_arbiter. It uses a small behavioural data generator
// (increment on a read rising edge, restart at 0 on srst) together with
// directed request sequences. Expected responses are queued by the stimulus,
// and a negedge monitor pops and compares them.
module tb_data_gen_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 32;
  localparam int W      = N_REQ + DATA_W;

  // ---------------- clock / reset ----------------
  logic              clock = 1'b0;
  logic              srst;
  logic              enable;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              gen_enable;
  logic              gen_read;
  logic [DATA_W-1:0] gen_data;
  logic [1:0]        state_dbg;

  always #5 clock = ~clock;

  data_gen_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clock      (clock),
    .srst       (srst),
    .enable     (enable),
    .req        (req),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .gen_enable (gen_enable),
    .gen_read   (gen_read),
    .gen_data   (gen_data),
    .state_dbg  (state_dbg)
  );

  // Generator model: one increment per read high phase, re-armed by read low.
  logic [DATA_W-1:0] gen_q;
  logic              gen_armed;
  assign gen_data = gen_q;

  always @(posedge clock or posedge srst) begin
    if (srst) begin
      gen_q     <= '0;
      gen_armed <= 1'b1;
    end else if (!gen_read) begin
      gen_armed <= 1'b1;
    end else if (gen_enable && gen_armed) begin
      gen_q     <= gen_q + 1'b1;
      gen_armed <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_exp(input int idx, input logic [DATA_W-1:0] d);
    exp_q.push_back({onehot(idx), d});
  endtask

  // Monitor: pops one expected response per rsp_valid pulse and checks the
  // grant/response exclusivity on every active cycle.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (!srst) begin
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: rsp_valid=%b rsp_data=%0d, expected no response", rsp_valid, rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_rsp", 64'({rsp_valid, rsp_data}), 64'(e));
          end
        end
        if (gnt != '0 || rsp_valid != '0) begin
          check("gnt_rsp_excl", 64'((gnt != '0) && (rsp_valid != '0)), 64'(0));
          check("gnt_onehot", 64'($countones(gnt) <= 1), 64'(1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    srst   = 1'b1;
    req    = '0;
    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1 srst = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Test 1: reset values, then a single one-cycle request.
    do_reset();
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_gen_read", 64'(gen_read), 64'(0));
    check("rst_gen_enable", 64'(gen_enable), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    push_exp(0, 1);
    req = 4'b0001;
    @(posedge clock);
    #1 req = '0;
    @(negedge clock);
    check("t1_gnt", 64'(gnt), 64'(4'b0001));
    check("t1_read_a", 64'(gen_read), 64'(1));
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_gen_en", 64'(gen_enable), 64'(1));
    cyc();
    check("t1_read_c", 64'(gen_read), 64'(1));
    cyc();
    check("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("t1_rsp_data", 64'(rsp_data), 64'(1));
    check("t1_read_r", 64'(gen_read), 64'(0));
    check("t1_gnt_clr", 64'(gnt), 64'(0));
    cyc();
    check("t1_pulse_end", 64'(rsp_valid), 64'(0));
    check("t1_data_hold", 64'(rsp_data), 64'(1));
    check("t1_idle", 64'(busy), 64'(0));

    // Test 2: all requesting -> grants 0,1,2,3,0 every 3 cycles, words 1..5.
    do_reset();
    for (int k = 0; k < 5; k++) push_exp(k % N_REQ, DATA_W'(k + 1));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t2_gnt", 64'(gnt), 64'(onehot(k % N_REQ)));
      if (k == 4) req = '0;
      @(posedge clock);
      cyc();
      check("t2_rsp_valid", 64'(rsp_valid), 64'(onehot(k % N_REQ)));
      check("t2_rsp_data", 64'(rsp_data), 64'(k + 1));
    end
    cyc();
    check("t2_idle", 64'(busy), 64'(0));

    // Test 3: last grant to 1, then req=1010 -> grant 3, then wrap to 1.
    do_reset();
    push_exp(1, 1);
    req = 4'b0010;
    cyc();
    check("t3_gnt1", 64'(gnt), 64'(4'b0010));
    req = '0;
    @(posedge clock);
    cyc();
    req = 4'b1010;
    push_exp(3, 2);
    push_exp(1, 3);
    cyc();
    check("t3_gnt3", 64'(gnt), 64'(4'b1000));
    repeat (2) @(posedge clock);
    cyc();
    check("t3_gnt1_wrap", 64'(gnt), 64'(4'b0010));
    req = '0;
    repeat (3) cyc();
    check("t3_idle", 64'(busy), 64'(0));

    // Test 4: enable low blocks grants; enable dropped in CAPTURE still completes.
    do_reset();
    enable = 1'b0;
    req    = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check("t4_no_gnt", 64'(gnt), 64'(0));
    end
    enable = 1'b1;
    push_exp(0, 1);
    cyc();
    check("t4_gnt", 64'(gnt), 64'(4'b0001));
    cyc();
    check("t4_in_capture", 64'(state_dbg), 64'(2));
    enable = 1'b0;
    cyc();
    check("t4_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    cyc();
    check("t4_idle_busy", 64'(busy), 64'(0));
    check("t4_idle_state", 64'(state_dbg), 64'(0));
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("t4_hold_off", 64'(gnt), 64'(0));
    end

    // Test 5: req0 dropped during ASSERT -> response still delivered, next word 2.
    enable = 1'b1;
    req    = 4'b0001;
    push_exp(0, 2);
    cyc();
    check("t5_gnt", 64'(gnt), 64'(4'b0001));
    req = '0;
    @(posedge clock);
    cyc();
    check("t5_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    check("t5_rsp_data", 64'(rsp_data), 64'(2));
    cyc();
    check("t5_idle", 64'(busy), 64'(0));

    // Test 6: srst during CAPTURE clears everything; generator restarts at 0.
    req = 4'b0001;
    cyc();
    req = '0;
    cyc();
    check("t6_in_capture", 64'(state_dbg), 64'(2));
    #2 srst = 1'b1;
    #1;
    check("t6_srst_gnt", 64'(gnt), 64'(0));
    check("t6_srst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("t6_srst_rsp_data", 64'(rsp_data), 64'(0));
    check("t6_srst_gen_read", 64'(gen_read), 64'(0));
    check("t6_srst_gen_enable", 64'(gen_enable), 64'(0));
    check("t6_srst_busy", 64'(busy), 64'(0));
    @(posedge clock);
    #1 srst = 1'b0;
    push_exp(0, 1);
    req = 4'b1111;
    cyc();
    check("t6_gnt0", 64'(gnt), 64'(4'b0001));
    req = '0;
    @(posedge clock);
    cyc();
    check("t6_rsp_data", 64'(rsp_data), 64'(1));

    // Drain: every queued response must have been observed.
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
